// File: rtl/rr_onehot_arbiter.sv
// -----------------------------------------------------------------------------
// rr_onehot_arbiter
// Round-robin arbiter among N requesters. It issues a registered one-hot grant
// and a matching registered binary index, using a valid/ready handshake.
//
// Optional feature macro: RR_ARB_LOCK_EN
//   Defined   : on a transfer with lock=1 while the owner is still requesting,
//               the owner is re-granted and the pointer is held.
//   Undefined : the lock input is ignored.
//
// Parameters
//   N   number of requesters (N >= 2, need not be a power of two)
//   IW  index width, derived as $clog2(N) (do not override)
//
// Ports
//   clk        in   1   clock; all state changes on the rising edge
//   rstn       in   1   asynchronous active-low reset
//   req        in   N   per-requester request level
//   lock       in   1   burst ownership request (RR_ARB_LOCK_EN only)
//   gnt_oh     out  N   one-hot grant; zero while gnt_valid=0
//   gnt_idx    out  IW  binary index of gnt_oh; zero while gnt_valid=0
//   gnt_valid  out  1   grant presented downstream
//   gnt_ready  in   1   downstream accepts the grant this cycle
// -----------------------------------------------------------------------------
module rr_onehot_arbiter #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  req,
    input  logic          lock,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid,
    input  logic          gnt_ready
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [IW-1:0] ptr_adv;
    logic [N-1:0]  oh_nxt;
    logic [IW-1:0] idx_nxt;
    logic [IW-1:0] win;

    // The first requester found when searching circularly from start.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r,
                                              input logic [IW-1:0] start);
        logic [IW-1:0] pick;
        logic          found;
        int            pos;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            pos = int'(start) + i;
            if (pos >= N) pos = pos - N;
            if (!found && r[pos[IW-1:0]]) begin
                found = 1'b1;
                pick  = pos[IW-1:0];
            end
        end
        return pick;
    endfunction

    function automatic logic [N-1:0] to_onehot(input logic [IW-1:0] idx);
        return {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

    // The pointer wraps explicitly at N-1, so values >= N never occur for
    // non-power-of-two N.
    assign ptr_adv = (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;

`ifndef RR_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = lock;
`endif

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        oh_nxt    = gnt_oh;
        idx_nxt   = gnt_idx;
        win       = '0;
        case (state)
            IDLE: begin
                // The pointer does not move on IDLE->GRANT.
                if (|req) begin
                    win       = rr_pick(req, ptr);
                    state_nxt = GRANT;
                    idx_nxt   = win;
                    oh_nxt    = to_onehot(win);
                end
            end
            GRANT: begin
                // With gnt_ready=0 the committed grant is held regardless of req.
                if (gnt_ready) begin
`ifdef RR_ARB_LOCK_EN
                    if (lock && req[gnt_idx]) begin
                        // Burst ownership: hold the pointer and re-grant the owner.
                        ptr_nxt = ptr;
                    end else
`endif
                    begin
                        ptr_nxt = ptr_adv;
                        if (|req) begin
                            // Back-to-back grant, searched from the updated pointer.
                            win     = rr_pick(req, ptr_adv);
                            idx_nxt = win;
                            oh_nxt  = to_onehot(win);
                        end else begin
                            state_nxt = IDLE;
                            idx_nxt   = '0;
                            oh_nxt    = '0;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
                oh_nxt    = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_oh  <= '0;
            gnt_idx <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gnt_oh  <= oh_nxt;
            gnt_idx <= idx_nxt;
        end
    end

    assign gnt_valid = (state == GRANT);

endmodule
